// File: rtl/conv_pixel_pack.sv
// Output stage after the convolution accumulator: normalise each sum to an
// 8-bit pixel, pack four pixels per word and buffer the words in a show-ahead FIFO.
module conv_pixel_pack #(
    parameter int SHIFT      = 8,
    parameter int ROUND      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sum_valid,
    input  logic [31:0] sum_data,
    input  logic        flush,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_last,
    output logic        overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [32:0] RND =
        (ROUND != 0 && SHIFT > 0) ? (33'sd1 <<< RSH) : 33'sd0;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    // Stage 1: normalise
    logic              pix_valid_q, pix_valid_d;
    logic [7:0]        pix_q, pix_d;
    logic              flush_q, flush_d;
    logic signed [32:0] sum_ext, sum_rnd, sum_shr;

    always_comb begin
        sum_ext     = $signed({sum_data[31], sum_data});
        sum_rnd     = sum_ext + RND;
        sum_shr     = sum_rnd >>> SHIFT;
        pix_valid_d = sum_valid;
        flush_d     = flush;
        if (sum_shr < 33'sd0) begin
            pix_d = 8'h00;
        end else if (sum_shr > 33'sd255) begin
            pix_d = 8'hFF;
        end else begin
            pix_d = sum_shr[7:0];
        end
    end

    // Stage 2: pack
    logic [1:0]       lane_q, lane_d;
    logic [2:0][7:0]  hold_q, hold_d;
    logic [31:0]      word_cur;
    logic             push;

    always_comb begin
        push = (pix_valid_q && (lane_q == 2'd3 || flush_q)) ||
               (!pix_valid_q && flush_q && lane_q != 2'd0);

        // Lanes at or above lane_q may hold stale bytes; mask them out.
        word_cur = '0;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < lane_q) word_cur[8*i +: 8] = hold_q[i];
        end
        if (pix_valid_q) begin
            case (lane_q)
                2'd0:    word_cur[7:0]   = pix_q;
                2'd1:    word_cur[15:8]  = pix_q;
                2'd2:    word_cur[23:16] = pix_q;
                default: word_cur[31:24] = pix_q;
            endcase
        end

        lane_d = lane_q;
        hold_d = hold_q;
        if (push) begin
            lane_d = 2'd0;
        end else if (pix_valid_q) begin
            lane_d = lane_q + 2'd1;
            case (lane_q)
                2'd0:    hold_d[0] = pix_q;
                2'd1:    hold_d[1] = pix_q;
                default: hold_d[2] = pix_q;
            endcase
        end
    end

    // Word FIFO; each entry is {last, word}
    logic [32:0]   mem_q [FIFO_DEPTH];
    logic [32:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          pop, full, push_ok;

    always_comb begin
        pop        = (count_q != '0) && word_ready;
        full       = (count_q == FULL_CNT);
        // A pop on the same edge frees the slot the push needs.
        push_ok    = push && (!full || pop);
        overflow_d = overflow_q | (push && full && !pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = {flush_q, word_cur};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid_q <= 1'b0;
            pix_q       <= '0;
            flush_q     <= 1'b0;
            lane_q      <= '0;
            hold_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pix_valid_q <= pix_valid_d;
            pix_q       <= pix_d;
            flush_q     <= flush_d;
            lane_q      <= lane_d;
            hold_q      <= hold_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        word_valid = (count_q != '0);
        word_data  = word_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
        word_last  = word_valid ? mem_q[rd_ptr_q][32] : 1'b0;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_conv_pixel_pack.sv
// Bench for conv_pixel_pack: normaliser table, directed multi-cycle sequences
// and a random run checked every cycle against a queue-based reference model.
module tb_conv_pixel_pack;

    localparam int SHIFT = 8;
    localparam int ROUND = 1;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sum_valid = 1'b0;
    logic [31:0] sum_data = '0;
    logic        flush = 1'b0;
    logic        word_ready = 1'b0;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_last;
    logic        overflow;

    conv_pixel_pack #(.SHIFT(SHIFT), .ROUND(ROUND), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sum_valid(sum_valid), .sum_data(sum_data),
        .flush(flush), .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .word_last(word_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pixel = clamp(floor((sum + round) / 2^SHIFT))
    function automatic logic [7:0] ref_pix(input logic [31:0] s);
        longint v;
        v = longint'($signed(s));
        if (ROUND != 0 && SHIFT > 0) v = v + (longint'(1) << (SHIFT - 1));
        v = v >>> SHIFT;
        if (v < 0) return 8'h00;
        if (v > 255) return 8'hFF;
        return 8'(v);
    endfunction

    // Transaction-level model: registered sample, list of pending pixels,
    // queue of {last, word} entries and a sticky overflow flag.
    bit          m_s1v, m_s1f, m_ovf;
    logic [7:0]  m_s1p;
    logic [7:0]  part_m[$];
    logic [32:0] fifo_m[$];

    always @(posedge clk) begin : model
        bit          pop_m;
        bit          push_m;
        logic [31:0] w;
        if (rst) begin
            m_s1v = 0; m_s1f = 0; m_s1p = '0; m_ovf = 0;
            part_m.delete();
            fifo_m.delete();
        end else begin
            pop_m  = (fifo_m.size() > 0) && word_ready;
            push_m = 0;
            w      = '0;
            if (m_s1v) part_m.push_back(m_s1p);
            if (part_m.size() > 0 && (part_m.size() == 4 || m_s1f)) begin
                foreach (part_m[i]) w[8*i +: 8] = part_m[i];
                part_m.delete();
                push_m = 1;
            end
            if (pop_m) void'(fifo_m.pop_front());
            if (push_m) begin
                if (fifo_m.size() < DEPTH) fifo_m.push_back({m_s1f, w});
                else m_ovf = 1;
            end
            m_s1v = sum_valid;
            m_s1f = flush;
            m_s1p = ref_pix(sum_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", 32'(word_valid), 32'(fifo_m.size() > 0));
            if (fifo_m.size() > 0) begin
                chk("model_data", word_data, fifo_m[0][31:0]);
                chk("model_last", 32'(word_last), 32'(fifo_m[0][32]));
            end
            chk("model_ovf", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic cyc(input bit v, input logic [31:0] d, input bit f, input bit r);
        @(negedge clk);
        sum_valid = v; sum_data = d; flush = f; word_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1; sum_valid = 0; flush = 0; word_ready = 0; sum_data = '0;
        repeat (n) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 0;
    endtask

    typedef struct {
        logic [31:0] sum;
        logic [7:0]  pix;
    } vec_t;
    vec_t tbl[12];

    logic [31:0] got[$];
    logic [31:0] exp_w[4];

    initial begin
        tbl[0]  = '{32'h0000_0000, 8'h00};
        tbl[1]  = '{32'h0000_007F, 8'h00};
        tbl[2]  = '{32'h0000_0080, 8'h01};
        tbl[3]  = '{32'h0000_3280, 8'h33};
        tbl[4]  = '{32'h0000_7F80, 8'h80};
        tbl[5]  = '{32'h0000_FF7F, 8'hFF};
        tbl[6]  = '{32'h0000_FF80, 8'hFF};
        tbl[7]  = '{32'h7FFF_FFFF, 8'hFF};
        tbl[8]  = '{32'h8000_0000, 8'h00};
        tbl[9]  = '{32'hFFFF_FF80, 8'h00};
        tbl[10] = '{32'hFFFF_FF7F, 8'h00};
        tbl[11] = '{32'h0000_1234, 8'h12};

        do_reset(2);
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_data", word_data, 32'h0);
        chk("rst_last", 32'(word_last), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk_en = 1;

        // Normaliser table: each sum alone, closed by a coincident flush
        foreach (tbl[k]) begin
            cyc(1, tbl[k].sum, 1, 0);
            cyc(0, 0, 0, 0);
            chk("tbl_valid", 32'(word_valid), 32'd1);
            chk("tbl_data", word_data, {24'h0, tbl[k].pix});
            chk("tbl_last", 32'(word_last), 32'd1);
            cyc(0, 0, 0, 1);
        end

        // Four pixels, latency of two edges from the last strobe
        cyc(1, 32'h0000_3280, 0, 0);
        cyc(1, 32'h0000_FFFF, 0, 0);
        cyc(1, 32'hFFFF_F000, 0, 0);
        cyc(1, 32'h0000_0100, 0, 0);
        chk("lat_e0_valid", 32'(word_valid), 32'd0);
        cyc(0, 0, 0, 0);
        chk("lat_e1_valid", 32'(word_valid), 32'd1);
        chk("w1_data", word_data, 32'h0100_FF33);
        chk("w1_last", 32'(word_last), 32'd0);
        cyc(0, 0, 0, 1);
        chk("w1_popped", 32'(word_valid), 32'd0);

        // Flush on second pixel, then a lone flush that must produce nothing
        cyc(1, 32'h0000_1000, 0, 0);
        cyc(1, 32'h0000_2000, 1, 0);
        cyc(0, 0, 0, 0);
        chk("fl_data", word_data, 32'h0000_2010);
        chk("fl_last", 32'(word_last), 32'd1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("empty_flush_valid", 32'(word_valid), 32'd0);
        chk("empty_flush_ovf", 32'(overflow), 32'd0);

        // 20 pixels into a stalled FIFO: 4 held, 5th dropped
        for (int i = 0; i < 4; i++)
            exp_w[i] = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 32'(i) << 8, 0, 0);
            if (i >= 6) chk("stall_head", word_data, exp_w[0]);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("stall_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(word_valid), 32'd1);
            chk("drain_data", word_data, exp_w[i]);
            cyc(0, 0, 0, 1);
        end
        chk("drain_empty", 32'(word_valid), 32'd0);
        chk("drain_ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO, pop on the same edge as the 5th word's push
        do_reset(1);
        for (int i = 1; i <= 20; i++) cyc(1, 32'(i) << 8, 0, 0);
        cyc(0, 0, 0, 1);
        chk("pp_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 4; i++) begin
            chk("pp_data", word_data, exp_w[i]);
            cyc(0, 0, 0, 1);
        end
        chk("pp_data5", word_data, 32'h1413_1211);
        cyc(0, 0, 0, 1);
        chk("pp_empty", 32'(word_valid), 32'd0);
        chk("pp_ovf_end", 32'(overflow), 32'd0);

        // Reset discards a partial word
        cyc(1, 32'h100, 0, 0);
        cyc(1, 32'h200, 0, 0);
        cyc(1, 32'h300, 0, 0);
        do_reset(1);
        for (int i = 0; i < 4; i++) cyc(1, 32'h100, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rstmid_data", word_data, 32'h0101_0101);
        chk("rstmid_valid", 32'(word_valid), 32'd1);
        cyc(0, 0, 0, 1);
        chk("rstmid_no_stale", 32'(word_valid), 32'd0);
        chk("rstmid_ovf", 32'(overflow), 32'd0);

        // Back-to-back streaming with ready held high
        got.delete();
        for (int i = 1; i <= 14; i++) begin
            if (word_valid) got.push_back(word_data);
            if (i <= 8) cyc(1, 32'(i) << 8, 0, 1);
            else cyc(0, 0, 0, 1);
        end
        chk("stream_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("stream_w0", got[0], 32'h0403_0201);
            chk("stream_w1", got[1], 32'h0807_0605);
        end

        // Random run against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] d;
            int rdy_pct;
            rdy_pct = (n < 1500) ? 20 : 70;
            case ($urandom_range(0, 3))
                0: d = $urandom;
                1: d = $urandom_range(0, 32'h1_0000);
                2: d = -$urandom_range(0, 32'h1000);
                default: d = 32'hFF00 + $urandom_range(0, 32'h100);
            endcase
            if ($urandom_range(0, 999) < 5) begin
                do_reset(1);
            end else begin
                cyc($urandom_range(0, 99) < 80, d, $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < rdy_pct);
            end
        end
        cyc(0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
